// File: rtl/onecount_pkg.sv
// Shared constants and state encoding for the ones-count arbiter slice.
package onecount_pkg;

    localparam int DW       = 16;
    localparam int COUNT_W  = 5;
    localparam int TOTAL_W  = 16;
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/onecount_popcount16.sv
// Combinational 16-bit ones counter shared by every requester.
module popcount16
    import onecount_pkg::*;
(
    input  logic [DW-1:0]      data_i,
    output logic [COUNT_W-1:0] count_o
);

    logic [COUNT_W-1:0] count_s;

    // Sum the individual bits; 16 ones needs the full 5-bit result.
    always_comb begin
        count_s = '0;
        for (int i = 0; i < DW; i++) begin
            count_s = count_s + COUNT_W'(data_i[i]);
        end
    end

    assign count_o = count_s;

endmodule

// File: rtl/onecount_arb.sv
// Round-robin arbiter that sequences NREQ producers through one popcount
// datapath and keeps a saturating total of all delivered counts.
module onecount_arb
    import onecount_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [COUNT_W-1:0]   res_count_o,
    output logic [IDW-1:0]       res_id_o,
    input  logic                 clr_i,
    output logic [TOTAL_W-1:0]   total_o,
    output logic                 busy_o
);

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [DW-1:0]        data_q, data_d;
    logic [IDW-1:0]       id_q, id_d;
    logic                 res_valid_q, res_valid_d;
    logic [COUNT_W-1:0]   res_count_q, res_count_d;
    logic [IDW-1:0]       res_id_q, res_id_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic                 busy_q, busy_d;

    logic [IDW-1:0]       win_s;
    logic [COUNT_W-1:0]   pc_count_s;
    logic                 hs_s;
    logic [TOTAL_W:0]     sum_s;

    // First set request at or above ptr, wrapping past the top index.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] win;
        logic           found;
        int unsigned    idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    popcount16 u_popcount (
        .data_i  (data_q),
        .count_o (pc_count_s)
    );

    assign hs_s = res_valid_q & res_ready_i;

    // Winner selection from the current round-robin pointer.
    always_comb begin
        win_s = rr_pick(req_i, ptr_q);
    end

    // Sequencer: grant in IDLE, count in CALC, hold the result until taken.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        data_d      = data_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_count_d = res_count_q;
        res_id_d    = res_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    data_d  = req_data_i[DW*win_s +: DW];
                    id_d    = win_s;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                res_count_d = pc_count_s;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                ptr_d       = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (hs_s) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Running total: clear has priority over a same-cycle handshake.
    always_comb begin
        sum_s = {1'b0, total_q} + (TOTAL_W+1)'(res_count_q);
        if (clr_i) begin
            total_d = '0;
        end else if (hs_s) begin
            total_d = sum_s[TOTAL_W] ? TOTAL_MAX : sum_s[TOTAL_W-1:0];
        end else begin
            total_d = total_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            data_q      <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_id_q    <= '0;
            total_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            data_q      <= data_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
            res_id_q    <= res_id_d;
            total_q     <= total_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign res_valid_o = res_valid_q;
    assign res_count_o = res_count_q;
    assign res_id_o    = res_id_q;
    assign total_o     = total_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_onecount_arb.sv
// Directed self-checking bench for onecount_arb (NREQ = 4).
module tb_onecount_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_count;
    logic [1:0]  res_id;
    logic        clr;
    logic [15:0] total;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    onecount_arb #(.NREQ(4), .IDW(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .req_data_i  (req_data),
        .gnt_o       (gnt),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_count_o (res_count),
        .res_id_o    (res_id),
        .clr_i       (clr),
        .total_o     (total),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [15:0] w);
        req_data[16*i +: 16] = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; req_data = 64'd0; res_ready = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({gnt, res_valid, res_count, res_id, total, busy} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b v=%b c=%0d id=%0d tot=%0d busy=%b want all 0",
                     gnt, res_valid, res_count, res_id, total, busy);
        end
        do_reset();
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_word(0, 16'h5555); req = 4'b0001; res_ready = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || res_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got gnt=%b v=%b busy=%b want 0001/0/1", gnt, res_valid, busy);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_count !== 5'd8 || res_id !== 2'd0) begin
            failures++;
            $display("FAIL single_result got gnt=%b v=%b c=%0d id=%0d want 0000/1/8/0",
                     gnt, res_valid, res_count, res_id);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || total !== 16'd8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_total got v=%b tot=%0d busy=%b want 0/8/0", res_valid, total, busy);
        end
    endtask

    task automatic test_all_four();
        int exp_id[4]  = '{0, 1, 2, 3};
        int exp_cnt[4] = '{16, 3, 6, 0};
        int ng = 0, nr = 0, last_g = -1, cyc = 0;
        do_reset();
        set_word(0, 16'hFFFF); set_word(1, 16'h0007); set_word(2, 16'h07E0); set_word(3, 16'h0000);
        req = 4'b1111; res_ready = 1'b1;
        while (nr < 4 && cyc < 40) begin
            step();
            cyc++;
            if (gnt !== 4'b0000 && ng < 4) begin
                checks++;
                if (gnt !== (4'b0001 << exp_id[ng])) begin
                    failures++;
                    $display("FAIL all4_grant[%0d] got %b want %b", ng, gnt, 4'b0001 << exp_id[ng]);
                end
                if (ng > 0) begin
                    checks++;
                    if (cyc - last_g != 3) begin
                        failures++;
                        $display("FAIL all4_spacing[%0d] got %0d want 3", ng, cyc - last_g);
                    end
                end
                last_g = cyc;
                req[exp_id[ng]] = 1'b0;
                ng++;
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (res_count !== 5'(exp_cnt[nr]) || res_id !== 2'(exp_id[nr])) begin
                    failures++;
                    $display("FAIL all4_result[%0d] got c=%0d id=%0d want c=%0d id=%0d",
                             nr, res_count, res_id, exp_cnt[nr], exp_id[nr]);
                end
                nr++;
            end
        end
        step();
        checks++;
        if (nr != 4 || total !== 16'd25) begin
            failures++;
            $display("FAIL all4_total got results=%0d tot=%0d want 4/25", nr, total);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_word(0, 16'h00F0); set_word(1, 16'h8001);
        req = 4'b0011; res_ready = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL bp_grant0 got %b want 0001", gnt);
        end
        req = 4'b0010;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_count !== 5'd4 || res_id !== 2'd0 || gnt !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b c=%0d id=%0d gnt=%b want 1/4/0/0000",
                         i, res_valid, res_count, res_id, gnt);
            end
            step();
        end
        res_ready = 1'b1;
        step();
        checks++;
        if (res_valid !== 1'b0 || gnt !== 4'b0000 || total !== 16'd4) begin
            failures++;
            $display("FAIL bp_handshake got v=%b gnt=%b tot=%0d want 0/0000/4", res_valid, gnt, total);
        end
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant1 got %b want 0010", gnt);
        end
        req = 4'b0000;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_count !== 5'd2 || res_id !== 2'd1) begin
            failures++;
            $display("FAIL bp_result1 got v=%b c=%0d id=%0d want 1/2/1", res_valid, res_count, res_id);
        end
        step();
        checks++;
        if (total !== 16'd6) begin
            failures++;
            $display("FAIL bp_total got %0d want 6", total);
        end
    endtask

    task automatic test_fairness();
        int ng = 0, cyc = 0;
        logic [3:0] last_gnt = 4'b0000;
        logic [3:0] exp_g;
        do_reset();
        set_word(0, 16'h0001); set_word(2, 16'h0003);
        req = 4'b0101; res_ready = 1'b1;
        while (ng < 6 && cyc < 60) begin
            step();
            cyc++;
            if (gnt !== 4'b0000) begin
                exp_g = (ng % 2 == 0) ? 4'b0001 : 4'b0100;
                checks++;
                if (gnt !== exp_g || gnt === last_gnt) begin
                    failures++;
                    $display("FAIL fair_grant[%0d] got %b prev %b want %b", ng, gnt, last_gnt, exp_g);
                end
                last_gnt = gnt;
                ng++;
            end
        end
        checks++;
        if (ng != 6) begin
            failures++;
            $display("FAIL fair_timeout got %0d grants want 6", ng);
        end
        req = 4'b0000;
    endtask

    task automatic test_saturation();
        int n_done = 0, cyc = 0;
        logic prev_valid = 1'b0;
        do_reset();
        set_word(0, 16'hFFFF); req = 4'b0001; res_ready = 1'b1;
        while (n_done < 4100 && cyc < 20000) begin
            step();
            cyc++;
            if (prev_valid) begin
                n_done++;
                if (n_done == 4095) begin
                    checks++;
                    if (total !== 16'hFFF0) begin
                        failures++;
                        $display("FAIL sat_4095 got %h want fff0", total);
                    end
                end
                if (n_done == 4096 || n_done == 4100) begin
                    checks++;
                    if (total !== 16'hFFFF) begin
                        failures++;
                        $display("FAIL sat_%0d got %h want ffff", n_done, total);
                    end
                end
            end
            prev_valid = res_valid;
        end
        checks++;
        if (n_done != 4100) begin
            failures++;
            $display("FAIL sat_timeout got %0d results want 4100", n_done);
        end
        req = 4'b0000;
        cyc = 0;
        while (busy === 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        set_word(0, 16'h001F); req = 4'b0001; res_ready = 1'b0;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_count !== 5'd5 || total !== 16'hFFFF) begin
            failures++;
            $display("FAIL clr_setup got v=%b c=%0d tot=%h want 1/5/ffff", res_valid, res_count, total);
        end
        clr = 1'b1; res_ready = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (total !== 16'd0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_handshake got tot=%h v=%b want 0/0", total, res_valid);
        end
    endtask

    task automatic test_reset_hold();
        set_word(1, 16'hFFFF); req = 4'b0010; res_ready = 1'b1;
        step();
        req = 4'b0000;
        step();
        step();
        set_word(2, 16'h000F); req = 4'b0100; res_ready = 1'b0;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd2 || total !== 16'd16) begin
            failures++;
            $display("FAIL rsthold_setup got v=%b id=%0d tot=%0d want 1/2/16", res_valid, res_id, total);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, res_valid, res_count, res_id, total, busy} !== 29'd0) begin
            failures++;
            $display("FAIL rsthold_outputs got gnt=%b v=%b c=%0d id=%0d tot=%0d busy=%b want all 0",
                     gnt, res_valid, res_count, res_id, total, busy);
        end
        #2;
        set_word(0, 16'h0001); set_word(1, 16'h0002); set_word(3, 16'h0004);
        req = 4'b1111; res_ready = 1'b1;
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rsthold_first_grant got %b want 0001", gnt);
        end
        req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; req_data = 64'd0; res_ready = 1'b0; clr = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_saturation();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
